ring_counter_gen: RTL

Parametrised shift-sequence counter: runtime-selectable ring (one-hot rotate) or Johnson (twisted-ring) mode, bidirectional stepping, count enable, parallel load and self-correction of illegal states. Width is set by parameter; all outputs are registered. Used as a sequencer and phase generator for digit multiplexing, stepper drives and lab demo blocks; it replaces fixed-width 4-bit ring counters.

---
 rtl/ring_counter_pkg.sv | 22 ++
 rtl/ring_legal_check.sv | 19 +
 rtl/ring_counter_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and home-state helper for the ring/Johnson sequence counter.
// MAX_WIDTH bounds the helper's return vector; callers slice it down to their width.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  localparam int MAX_WIDTH = 64;

  // Ring home is one-hot at home_bit; Johnson home is all zeros.
  function automatic logic [MAX_WIDTH-1:0] home_state(input logic mode, input int width,
                                                      input int home_bit);
    logic [MAX_WIDTH-1:0] h;
    h = '0;
    if (mode == MODE_RING && home_bit >= 0 && home_bit < width && home_bit < MAX_WIDTH)
      h[home_bit] = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/ring_legal_check.sv
// Combinational legality test: one-hot in ring mode, thermometer in Johnson mode.
// Zero latency; no flow control.
module ring_legal_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             legal
);

  // A thermometer pattern (either polarity) has at most one adjacent-bit transition.
  logic [WIDTH-2:0] edges;

  assign edges = value[WIDTH-1:1] ^ value[WIDTH-2:0];
  assign legal = (mode == MODE_RING) ? ($countones(value) == 1) : ($countones(edges) <= 1);

endmodule

// File: rtl/ring_counter_gen.sv
// Ring / Johnson shift-sequence counter with load, bidirectional step and self-correction.
// One-cycle registered latency on count/wrap/illegal; no backpressure, en gates stepping.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOME_BIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [MAX_WIDTH-1:0] HOME_RING_FULL = home_state(MODE_RING, WIDTH, HOME_BIT);
  localparam logic [MAX_WIDTH-1:0] HOME_JOHN_FULL = home_state(MODE_JOHNSON, WIDTH, HOME_BIT);
  localparam logic [WIDTH-1:0]     HOME_RING      = HOME_RING_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     HOME_JOHN      = HOME_JOHN_FULL[WIDTH-1:0];

  logic             mode_q;
  logic             load_legal;
  logic             count_legal;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] home_in;
  logic [WIDTH-1:0] home_cur;

  ring_legal_check #(.WIDTH(WIDTH)) u_load_chk (
    .value (load_value),
    .mode  (mode),
    .legal (load_legal)
  );

  // The held state is judged against the mode it was produced in.
  ring_legal_check #(.WIDTH(WIDTH)) u_count_chk (
    .value (count),
    .mode  (mode_q),
    .legal (count_legal)
  );

  assign home_in  = (mode == MODE_JOHNSON) ? HOME_JOHN : HOME_RING;
  assign home_cur = (mode_q == MODE_JOHNSON) ? HOME_JOHN : HOME_RING;

  always_comb begin
    stepped = count;
    if (mode_q == MODE_RING) begin
      if (dir == DIR_LEFT) stepped = {count[WIDTH-2:0], count[WIDTH-1]};
      else                 stepped = {count[0], count[WIDTH-1:1]};
    end else begin
      if (dir == DIR_LEFT) stepped = {count[WIDTH-2:0], ~count[WIDTH-1]};
      else                 stepped = {~count[0], count[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    wrap    <= 1'b0;
    illegal <= 1'b0;
    if (reset) begin
      count  <= home_in;
      mode_q <= mode;
    end else if (load) begin
      mode_q <= mode;
      if (load_legal) begin
        count <= load_value;
      end else begin
        count   <= home_in;
        illegal <= 1'b1;
      end
    end else if (mode != mode_q) begin
      // Resync to the new mode's home; the old pattern is meaningless there.
      count  <= home_in;
      mode_q <= mode;
    end else if (en) begin
      if (!count_legal) begin
        count   <= home_cur;
        illegal <= 1'b1;
      end else begin
        count <= stepped;
        wrap  <= (stepped == home_cur);
      end
    end
  end

endmodule
